// File: rtl/shift_pkg.sv
// Shared encodings for the shift engine: command modes and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_LOAD    = 3'd0,
        MODE_SHL     = 3'd1,
        MODE_SHR     = 3'd2,
        MODE_ROL     = 3'd3,
        MODE_ROR     = 3'd4,
        MODE_JOHNSON = 3'd5,
        MODE_THERMO  = 3'd6,
        MODE_CLEAR   = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-step next-state function of the shift register for every mode.
module shift_step import shift_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // One step of the selected mode; LOAD is not a step mode and holds q.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_JOHNSON: begin
                q_next  = {q[WIDTH-2:0], ~q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_THERMO: begin
                q_next  = {q[WIDTH-2:0], 1'b1};
                out_bit = q[WIDTH-1];
            end
            MODE_CLEAR: begin
                q_next  = '0;
                out_bit = 1'b0;
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Command-driven WIDTH-bit shift register with multi-step counts; all state
// moves on the falling clock edge.
module shift_engine import shift_pkg::*; #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_r;
    mode_e            mode_r;
    logic [CNT_W-1:0] remaining_r;
    logic [WIDTH-1:0] q_r;
    logic             ser_out_r;
    logic [WIDTH-1:0] step_q_s;
    logic             step_bit_s;
    mode_e            cmd_mode_s;

    assign cmd_mode_s = mode_e'(cmd_mode);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_r),
        .mode    (mode_r),
        .ser_in  (ser_in),
        .q_next  (step_q_s),
        .out_bit (step_bit_s)
    );

    // Control FSM, step counter, mode latch and datapath registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_LOAD;
            remaining_r <= '0;
            q_r         <= '0;
            ser_out_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_r <= cmd_mode_s;
                        case (cmd_mode_s)
                            MODE_LOAD: begin
                                q_r         <= load_data;
                                ser_out_r   <= 1'b0;
                                remaining_r <= '0;
                                state_r     <= ST_DONE;
                            end
                            MODE_CLEAR: begin
                                q_r         <= '0;
                                ser_out_r   <= 1'b0;
                                remaining_r <= '0;
                                state_r     <= ST_DONE;
                            end
                            default: begin
                                remaining_r <= cmd_amt;
                                state_r     <= (cmd_amt == '0) ? ST_DONE : ST_RUN;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    q_r         <= step_q_s;
                    ser_out_r   <= step_bit_s;
                    remaining_r <= remaining_r - CNT_ONE;
                    // Leave RUN on the edge that performs the final step.
                    state_r     <= (remaining_r == CNT_ONE) ? ST_DONE : ST_RUN;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign q         = q_r;
    assign ser_out   = ser_out_r;
    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine (WIDTH=8): hand-computed patterns, timing,
// handshake and asynchronous reset behaviour.
module tb_shift_engine;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [3:0] cmd_amt;
    logic [7:0] load_data;
    logic       ser_in;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int n_checks;
    int n_pass;

    shift_engine #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_amt   (cmd_amt),
        .load_data (load_data),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Issue one command and follow it to completion. Inputs change and
    // outputs are sampled on rising edges, away from the active falling edge.
    task automatic run_cmd(input string tag, input logic [2:0] m, input logic [3:0] a,
                           input logic [7:0] d, input logic s, input int steps,
                           input logic [7:0] exp_q);
        int cyc;
        int busy_cnt;
        @(posedge clk);
        check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_mode = m; cmd_amt = a; load_data = d; ser_in = s; cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        cmd_valid = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, steps);
        check({tag, " busy_cycles"}, busy_cnt, steps);
        check({tag, " q"}, {24'd0, q}, {24'd0, exp_q});
        @(posedge clk);
        check({tag, " done_pulse"}, {30'd0, done, cmd_ready}, 32'd1);
    endtask

    initial begin
        int dcnt;
        n_checks = 0; n_pass = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_amt = 4'd0;
        load_data = 8'd0; ser_in = 1'b0;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        check("reset_state", {20'd0, q, ser_out, busy, done, cmd_ready}, {20'd0, 8'h00, 4'b0001});

        run_cmd("clear0", 3'd7, 4'd5, 8'h00, 1'b0, 0, 8'h00);
        run_cmd("thermo3", 3'd6, 4'd3, 8'h00, 1'b0, 3, 8'h07);
        run_cmd("clear1", 3'd7, 4'd0, 8'h00, 1'b0, 0, 8'h00);
        run_cmd("thermo8", 3'd6, 4'd8, 8'h00, 1'b0, 8, 8'hFF);

        run_cmd("load_a5", 3'd0, 4'd9, 8'hA5, 1'b0, 0, 8'hA5);
        run_cmd("rol4", 3'd3, 4'd4, 8'h00, 1'b0, 4, 8'h5A);
        run_cmd("ror12", 3'd4, 4'd12, 8'h00, 1'b0, 12, 8'hA5);

        // Asynchronous reset in the middle of the high phase.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", {20'd0, q, ser_out, busy, done, cmd_ready}, {20'd0, 8'h00, 4'b0001});
        @(posedge clk);
        reset = 1'b0;

        run_cmd("john3", 3'd5, 4'd3, 8'h00, 1'b0, 3, 8'h07);
        run_cmd("john8", 3'd5, 4'd5, 8'h00, 1'b0, 5, 8'hFF);
        run_cmd("john16", 3'd5, 4'd8, 8'h00, 1'b0, 8, 8'h00);
        check("john16 ser_out", {31'd0, ser_out}, 32'd1);

        run_cmd("load_81", 3'd0, 4'd0, 8'h81, 1'b0, 0, 8'h81);
        check("load ser_out", {31'd0, ser_out}, 32'd0);
        run_cmd("shr1", 3'd2, 4'd1, 8'h00, 1'b1, 1, 8'hC0);
        check("shr1 ser_out", {31'd0, ser_out}, 32'd1);
        run_cmd("shl2", 3'd1, 4'd2, 8'h00, 1'b0, 2, 8'h00);
        check("shl2 ser_out", {31'd0, ser_out}, 32'd1);

        run_cmd("load_3c", 3'd0, 4'd0, 8'h3C, 1'b0, 0, 8'h3C);
        run_cmd("shl0", 3'd1, 4'd0, 8'h00, 1'b1, 0, 8'h3C);
        run_cmd("shl_flush", 3'd1, 4'd9, 8'h00, 1'b1, 9, 8'hFF);
        check("flush ser_out", {31'd0, ser_out}, 32'd1);
        run_cmd("shr_flush", 3'd2, 4'd15, 8'h00, 1'b0, 15, 8'h00);

        // cmd_valid held high throughout: only one ROL command may run.
        run_cmd("load_01", 3'd0, 4'd0, 8'h01, 1'b0, 0, 8'h01);
        @(posedge clk);
        cmd_mode = 3'd3; cmd_amt = 4'd3; cmd_valid = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (done) begin
                dcnt++;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("held_valid done_count", dcnt, 1);
        check("held_valid q", {24'd0, q}, 32'h08);

        // Reset after the second of five THERMO steps aborts the command.
        run_cmd("clear2", 3'd7, 4'd0, 8'h00, 1'b0, 0, 8'h00);
        @(posedge clk);
        cmd_mode = 3'd6; cmd_amt = 4'd5; cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        check("mid_cmd q_before", {24'd0, q}, 32'h03);
        #1 reset = 1'b1;
        #1 check("mid_cmd reset", {20'd0, q, ser_out, busy, done, cmd_ready}, {20'd0, 8'h00, 4'b0001});
        @(posedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (done) dcnt++;
        end
        check("mid_cmd no_done", dcnt, 0);
        check("mid_cmd idle", {24'd0, q, 6'd0, busy, cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
